// File: rtl/square_wave_gen_if.sv
// Configuration port of square_wave_gen: period/high-time offer with valid/ready.
// Latency: none, wires only.
// Backpressure: the slave holds cfg_ready low while its one-entry shadow is full.
//
// Signals:
//   cfg_period  requested period in clk cycles (0 = stop request)
//   cfg_high    requested high time in clk cycles (honoured only with duty control built in)
//   cfg_valid   offer from the master
//   cfg_ready   accept from the slave
interface square_wave_gen_if #(
    parameter int COUNTER_WIDTH = 18
);
    logic [COUNTER_WIDTH-1:0] cfg_period;
    logic [COUNTER_WIDTH-1:0] cfg_high;
    logic                     cfg_valid;
    logic                     cfg_ready;

    modport master (
        output cfg_period,
        output cfg_high,
        output cfg_valid,
        input  cfg_ready
    );

    modport slave (
        input  cfg_period,
        input  cfg_high,
        input  cfg_valid,
        output cfg_ready
    );
endinterface

// File: rtl/square_wave_gen.sv
// Programmable square-wave generator, period N clk cycles, config applied only at period boundaries.
// Latency: config accepted in cycle N from IDLE -> first sq_out high in cycle N+2.
// Backpressure: one-entry shadow; cfg.cfg_ready low while a config is pending.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   en            run enable; dropping it stops the generator at the end of the current period
//   cfg           square_wave_gen_if.slave config port (period, high time, valid/ready)
//   sq_out        registered square wave
//   period_start  one-cycle pulse with each rising edge of sq_out
//   running       generator is in RUN
//   cur_period    period currently being generated
//
// Build option: define SQGEN_DUTY_CTRL_EN to honour cfg_high (clamped to 1..P-1);
// otherwise cfg_high is ignored and the high time is P>>1.
module square_wave_gen #(
    parameter int COUNTER_WIDTH = 18
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    square_wave_gen_if.slave         cfg,
    output logic                     sq_out,
    output logic                     period_start,
    output logic                     running,
    output logic [COUNTER_WIDTH-1:0] cur_period
);

    localparam logic [COUNTER_WIDTH-1:0] ZERO = '0;
    localparam logic [COUNTER_WIDTH-1:0] ONE  = COUNTER_WIDTH'(1);
    localparam logic [COUNTER_WIDTH-1:0] TWO  = COUNTER_WIDTH'(2);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                   state, state_n;
    logic [COUNTER_WIDTH-1:0] cnt, cnt_n;
    logic [COUNTER_WIDTH-1:0] cur_high, cur_high_n;
    logic [COUNTER_WIDTH-1:0] cur_period_n;
    logic                     sq_out_n, period_start_n, running_n;

    logic [COUNTER_WIDTH-1:0] pend_period;
    logic [COUNTER_WIDTH-1:0] pend_high;
    logic                     pend_valid;
    logic                     consume;

    logic                     cfg_accept;
    logic [COUNTER_WIDTH-1:0] cfg_period_cl;

    assign cfg.cfg_ready = ~pend_valid;
    assign cfg_accept    = cfg.cfg_valid && ~pend_valid;
    // A one-cycle period cannot hold both a high and a low cycle.
    assign cfg_period_cl = (cfg.cfg_period == ONE) ? TWO : cfg.cfg_period;

    // ---------------- config shadow ----------------
    // Accept and consume are mutually exclusive: accept needs the shadow empty,
    // consume needs it full.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_valid  <= 1'b0;
            pend_period <= ZERO;
        end else if (consume) begin
            pend_valid  <= 1'b0;
        end else if (cfg_accept) begin
            pend_valid  <= 1'b1;
            pend_period <= cfg_period_cl;
        end
    end

`ifdef SQGEN_DUTY_CTRL_EN
    // High time clamped to 1..P-1 so the output always toggles while running.
    // For a stop request (P=0) the value is never used.
    logic [COUNTER_WIDTH-1:0] cfg_high_cl;
    always_comb begin
        cfg_high_cl = cfg.cfg_high;
        if (cfg.cfg_high == ZERO)
            cfg_high_cl = ONE;
        else if (cfg.cfg_high >= cfg_period_cl)
            cfg_high_cl = cfg_period_cl - ONE;
    end

    always_ff @(posedge clk) begin
        if (rst)
            pend_high <= ZERO;
        else if (cfg_accept)
            pend_high <= cfg_high_cl;
    end
`else
    // Fixed 50% duty: odd periods get the extra cycle in the low phase.
    logic cfg_high_unused;
    assign cfg_high_unused = ^cfg.cfg_high;
    assign pend_high       = pend_period >> 1;
`endif

    // ---------------- state registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= ZERO;
            cur_period   <= ZERO;
            cur_high     <= ZERO;
            sq_out       <= 1'b0;
            period_start <= 1'b0;
            running      <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            cur_period   <= cur_period_n;
            cur_high     <= cur_high_n;
            sq_out       <= sq_out_n;
            period_start <= period_start_n;
            running      <= running_n;
        end
    end

    // ---------------- next state / outputs ----------------
    logic boundary;
    logic do_load, do_stop, do_repeat;

    assign boundary = (cnt == cur_period - ONE);

    always_comb begin
        do_load   = 1'b0;
        do_stop   = 1'b0;
        do_repeat = 1'b0;
        consume   = 1'b0;

        if (state == IDLE) begin
            if (pend_valid) begin
                if (pend_period == ZERO)
                    consume = 1'b1;          // stop request with nothing running
                else if (en)
                    do_load = 1'b1;
            end
        end else if (boundary) begin
            // New period wins, then a stop request, then en; otherwise repeat.
            if (pend_valid && pend_period != ZERO) begin
                do_load = 1'b1;
            end else if (pend_valid) begin
                consume = 1'b1;
                do_stop = 1'b1;
            end else if (!en) begin
                do_stop = 1'b1;
            end else begin
                do_repeat = 1'b1;
            end
        end
        if (do_load)
            consume = 1'b1;
    end

    always_comb begin
        state_n        = state;
        cnt_n          = cnt;
        cur_period_n   = cur_period;
        cur_high_n     = cur_high;
        sq_out_n       = sq_out;
        period_start_n = 1'b0;
        running_n      = running;

        if (do_load) begin
            state_n        = RUN;
            cur_period_n   = pend_period;
            cur_high_n     = pend_high;
            cnt_n          = ZERO;
            sq_out_n       = 1'b1;
            period_start_n = 1'b1;
            running_n      = 1'b1;
        end else if (do_stop) begin
            state_n   = IDLE;
            cnt_n     = ZERO;
            sq_out_n  = 1'b0;
            running_n = 1'b0;
        end else if (do_repeat) begin
            // H >= 1 always holds (P >= 2), so the first cycle is high.
            cnt_n          = ZERO;
            sq_out_n       = 1'b1;
            period_start_n = 1'b1;
        end else if (state == RUN) begin
            cnt_n    = cnt + ONE;
            sq_out_n = ((cnt + ONE) < cur_high);
        end
    end

endmodule

// File: tb/tb_square_wave_gen.sv
// Self-checking bench for square_wave_gen: directed configs, scoreboard of per-period high/low counts.
// Latency: n/a (testbench).
// Backpressure: config offers are held until the generator raises cfg_ready.
module tb_square_wave_gen;

    localparam int W = 18;
    localparam int BOUND = 5000;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         sq_out;
    logic         period_start;
    logic         running;
    logic [W-1:0] cur_period;

    square_wave_gen_if #(.COUNTER_WIDTH(W)) cfg_if ();

    square_wave_gen #(.COUNTER_WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .cfg          (cfg_if),
        .sq_out       (sq_out),
        .period_start (period_start),
        .running      (running),
        .cur_period   (cur_period)
    );

    always #5 clk = ~clk;

    typedef struct {
        int hi;
        int lo;
        int per;
    } rec_t;

    rec_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    task automatic push(input int hi, input int lo, input int per);
        rec_t r;
        r.hi  = hi;
        r.lo  = lo;
        r.per = per;
        sb.push_back(r);
    endtask

    // ---------------- monitor ----------------
    // One record per generated period: opened by period_start, closed by the next
    // period_start or by running falling. Reset discards any open record.
    bit mon_open = 1'b0;
    int mon_hi, mon_lo, mon_per;

    task automatic close_record();
        rec_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_period: got hi=%0d lo=%0d per=%0d, expected none",
                     mon_hi, mon_lo, mon_per);
        end else begin
            e = sb.pop_front();
            chk("period_high", mon_hi, e.hi);
            chk("period_low", mon_lo, e.lo);
            chk("cur_period", mon_per, e.per);
        end
        mon_open = 1'b0;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_open = 1'b0;
            end else begin
                if (mon_open && (period_start || !running))
                    close_record();
                if (period_start) begin
                    mon_open = 1'b1;
                    mon_hi   = 0;
                    mon_lo   = 0;
                    mon_per  = int'(cur_period);
                end
                if (mon_open) begin
                    if (sq_out) mon_hi++;
                    else        mon_lo++;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_cfg(input int p, input int h);
        int waited = 0;
        @(negedge clk);
        cfg_if.cfg_period = W'(p);
        cfg_if.cfg_high   = W'(h);
        cfg_if.cfg_valid  = 1'b1;
        while (!cfg_if.cfg_ready && waited < BOUND) begin
            @(negedge clk);
            waited++;
        end
        chk("cfg_accepted_in_time", (waited < BOUND) ? 1 : 0, 1);
        @(posedge clk);
        #1 cfg_if.cfg_valid = 1'b0;
    endtask

    task automatic wait_start();
        int waited = 0;
        @(negedge clk);
        while (!period_start && waited < BOUND) begin
            @(negedge clk);
            waited++;
        end
        chk("period_start_seen", (waited < BOUND) ? 1 : 0, 1);
    endtask

    task automatic wait_stop();
        int waited = 0;
        @(negedge clk);
        while (running && waited < BOUND) begin
            @(negedge clk);
            waited++;
        end
        chk("stopped_in_time", (waited < BOUND) ? 1 : 0, 1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_sq_out"}, int'(sq_out), 0);
        chk({tag, "_period_start"}, int'(period_start), 0);
        chk({tag, "_running"}, int'(running), 0);
        chk({tag, "_cur_period"}, int'(cur_period), 0);
        chk({tag, "_cfg_ready"}, int'(cfg_if.cfg_ready), 1);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        rst               = 1'b1;
        en                = 1'b0;
        cfg_if.cfg_valid  = 1'b0;
        cfg_if.cfg_period = '0;
        cfg_if.cfg_high   = '0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b0;
        en  = 1'b1;

        // P=200 from IDLE: pending one cycle, then first high cycle.
        push(100, 100, 200);
        send_cfg(200, 0);
        @(negedge clk);
        chk("lat_pending_sq_out", int'(sq_out), 0);
        chk("lat_pending_cfg_ready", int'(cfg_if.cfg_ready), 0);
        @(negedge clk);
        chk("lat_first_sq_out", int'(sq_out), 1);
        chk("lat_first_period_start", int'(period_start), 1);
        chk("lat_first_running", int'(running), 1);
        chk("lat_first_cur_period", int'(cur_period), 200);

        // Mid-period offer of 2000: shadow fills, applied at the 200 boundary.
        repeat (50) @(negedge clk);
        push(1000, 1000, 2000);
        send_cfg(2000, 0);
        @(negedge clk);
        chk("shadow_full_cfg_ready", int'(cfg_if.cfg_ready), 0);
        // These offers each wait for the shadow to drain.
        push(3, 4, 7);
        send_cfg(7, 0);
        push(1, 1, 2);
        send_cfg(1, 0);            // clamped to 2
        send_cfg(0, 0);            // stop after the P=2 period
        wait_stop();
        @(negedge clk);
        chk("stop_sq_out", int'(sq_out), 0);
        chk("stop_running", int'(running), 0);

        // Stop request while idle is swallowed.
        send_cfg(0, 0);
        repeat (3) @(negedge clk);
        chk("idle_zero_running", int'(running), 0);
        chk("idle_zero_cfg_ready", int'(cfg_if.cfg_ready), 1);

        // en dropped mid-period then restored before the boundary keeps running;
        // dropped again in the second period stops at its boundary.
        push(100, 100, 200);
        push(100, 100, 200);
        send_cfg(200, 0);
        wait_start();
        repeat (49) @(negedge clk);
        en = 1'b0;
        repeat (100) @(negedge clk);
        en = 1'b1;
        wait_start();
        repeat (30) @(negedge clk);
        en = 1'b0;
        wait_stop();
        chk("en_stop_sq_out", int'(sq_out), 0);
        chk("en_stop_cur_period", int'(cur_period), 200);
        en = 1'b1;

        // High-time control.
`ifdef SQGEN_DUTY_CTRL_EN
        push(25, 75, 100);
        push(1, 99, 100);
        push(99, 1, 100);
`else
        push(50, 50, 100);
        push(50, 50, 100);
        push(50, 50, 100);
`endif
        send_cfg(100, 25);
        send_cfg(100, 0);
        send_cfg(100, 150);
        send_cfg(0, 0);
        wait_stop();

        // Reset in the high phase: no tail, all outputs at reset values.
        send_cfg(200, 0);
        wait_start();
        repeat (10) @(negedge clk);
        chk("pre_reset_sq_out", int'(sq_out), 1);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_outputs("midrun_reset");
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("post_reset_running", int'(running), 0);

        chk("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
